// File: rtl/perf_report_pkg.sv
// Shared types and constants for the performance-counter UART report path.
package perf_report_pkg;

    localparam int         FRAME_BYTES    = 10;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    function automatic logic [7:0] frame_checksum(input logic [31:0] hi, input logic [31:0] lo);
        return hi[31:24] ^ hi[23:16] ^ hi[15:8] ^ hi[7:0]
             ^ lo[31:24] ^ lo[23:16] ^ lo[15:8] ^ lo[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser with a valid/ready handshake.
// state | meaning
// IDLE  | line idle high, ready for a byte
// START | start bit (0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1); on its last cycle a new byte may be taken with no gap
module uart_tx_byte
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        baud_end   = (baud_q == BAUD_LAST);
        byte_done  = (state_q == STOP) && baud_end;
        byte_ready = (state_q == IDLE) || byte_done;

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (baud_end) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (baud_end) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
            default: ;
        endcase

        // Loading on the final stop cycle gives back-to-back bytes with no idle gap.
        if (byte_ready && byte_valid) begin
            state_d = START;
            baud_d  = '0;
            shift_d = data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/perf_report_uart_tx.sv
// Snapshots the valid/bubble cycle counters and streams them as a 10-byte UART frame.
// state | meaning
// IDLE  | waiting for snapshot_req
// NEXT  | frame in flight; hands the next byte over as each byte finishes
module perf_report_uart_tx
    import perf_report_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snapshot_req,
    input  logic [31:0] high_count,
    input  logic [31:0] low_count,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  byte_sel;
    logic [31:0] hi_q, lo_q;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        accept;
    logic        byte_valid, byte_ready, byte_done;
    logic [7:0]  byte_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_sel   = idx_q;
        byte_valid = 1'b0;
        accept     = 1'b0;
        done_d     = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: if (snapshot_req && byte_ready) begin
                accept     = 1'b1;
                state_d    = NEXT;
                idx_d      = '0;
                byte_sel   = '0;
                byte_valid = 1'b1;
                overrun_d  = 1'b0;
            end
            NEXT: begin
                if (snapshot_req) overrun_d = 1'b1;
                if (byte_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        byte_sel   = idx_q + 4'd1;
                        byte_valid = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Header needs no snapshot, so the mux is valid on the same edge the counts latch.
    always_comb begin
        case (byte_sel)
            4'd0:    byte_data = HEADER_BYTE;
            4'd1:    byte_data = hi_q[31:24];
            4'd2:    byte_data = hi_q[23:16];
            4'd3:    byte_data = hi_q[15:8];
            4'd4:    byte_data = hi_q[7:0];
            4'd5:    byte_data = lo_q[31:24];
            4'd6:    byte_data = lo_q[23:16];
            4'd7:    byte_data = lo_q[15:8];
            4'd8:    byte_data = lo_q[7:0];
            default: byte_data = frame_checksum(hi_q, lo_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            if (accept) begin
                hi_q <= high_count;
                lo_q <= low_count;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .data      (byte_data),
        .tx        (tx),
        .byte_done (byte_done)
    );

    assign busy    = (state_q == NEXT);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_perf_report_uart_tx.sv
// Scoreboard bench: expected frame bytes are queued at request time and matched by a UART line decoder.
module tb_perf_report_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        snapshot_req = 1'b0;
    logic [31:0] high_count = '0;
    logic [31:0] low_count = '0;
    logic        tx, busy, done, overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    int         flush_req = 0;

    always #5 clk = ~clk;

    perf_report_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .snapshot_req(snapshot_req),
        .high_count  (high_count),
        .low_count   (low_count),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] w;
        logic [7:0]  c;
        logic [7:0]  b;
        w = {hi, lo};
        c = 8'h00;
        sb.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            b = w[i*8 +: 8];
            c = c ^ b;
            sb.push_back(b);
        end
        sb.push_back(c);
    endtask

    // Line decoder: samples mid-bit, pops the scoreboard on every stop bit.
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    int         flush_seen = 0;
    logic [7:0] rx_byte = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (flush_seen != flush_req) begin
            flush_seen = flush_req;
            rx_active  = 1'b0;
            sb.delete();
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_active && (rx_cnt % CPB) == CPB / 2) begin
            case (rx_cnt / CPB)
                0: check_eq("start_bit", tx, 1'b0);
                9: begin
                    check_eq("stop_bit", tx, 1'b1);
                    rx_active = 1'b0;
                    check_eq("sb_nonempty", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        check_eq("frame_byte", rx_byte, exp_b);
                    end
                end
                default: rx_byte[rx_cnt / CPB - 1] = tx;
            endcase
        end
    end

    task automatic run_frame(input logic [31:0] hi, input logic [31:0] lo,
                             input int zero_at, input int req2_at, input bit exp_ovr,
                             input bit pre, input bit chain,
                             input logic [31:0] nhi, input logic [31:0] nlo);
        int n;
        int busy_drop;
        bit got;
        if (!pre) begin
            high_count = hi;
            low_count  = lo;
            push_frame(hi, lo);
            @(negedge clk);
            snapshot_req = 1'b1;
        end
        @(negedge clk);
        snapshot_req = 1'b0;
        check_eq("first_start", {tx, busy, done, overrun}, 4'b0100);
        n = 0;
        got = 1'b0;
        busy_drop = 0;
        while (!got && n < 1000) begin
            @(negedge clk);
            n++;
            snapshot_req = (n == req2_at);
            if (n == zero_at) begin
                high_count = '0;
                low_count  = '0;
            end
            if (done) begin
                got = 1'b1;
                check_eq("frame_time", n, 100 * CPB);
                check_eq("done_busy_ovr", {busy, overrun}, {1'b0, exp_ovr});
                if (chain) begin
                    high_count = nhi;
                    low_count  = nlo;
                    push_frame(nhi, nlo);
                    snapshot_req = 1'b1;
                end
            end else if (!busy) begin
                busy_drop++;
            end
        end
        check_eq("done_seen", got, 1'b1);
        check_eq("busy_held", busy_drop, 0);
        if (!chain) begin
            @(negedge clk);
            check_eq("done_pulse", {done, busy}, 2'b00);
            check_eq("sb_drained", sb.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("idle_after_reset", {tx, busy, done, overrun}, 4'b1000);
        end

        run_frame(32'h0000_0010, 32'h0000_0003, -1, -1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(32'h1234_5678, 32'h9ABC_DEF0, 10, -1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(32'hCAFE_BABE, 32'h0102_0304, -1, 50, 1'b1, 1'b0, 1'b0, '0, '0);

        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if ({tx, busy, overrun} !== 3'b101) bad++;
        end
        check_eq("overrun_sticky_idle", bad, 0);

        run_frame(32'hDEAD_BEEF, 32'h0000_0001, -1, -1, 1'b0, 1'b0, 1'b0, '0, '0);

        high_count = 32'h0BAD_F00D;
        low_count  = 32'h7654_3210;
        push_frame(high_count, low_count);
        @(negedge clk);
        snapshot_req = 1'b1;
        @(negedge clk);
        snapshot_req = 1'b0;
        repeat (150) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        flush_req++;
        check_eq("mid_frame_reset", {tx, busy, done, overrun}, 4'b1000);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("no_restart", bad, 0);

        run_frame(32'hA1B2_C3D4, 32'hE5F6_0718, -1, -1, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFE);
        run_frame('0, '0, -1, -1, 1'b0, 1'b1, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
